// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// constants and ALU control codes.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExec = 4'd6,
        StRtWb   = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU control decode; valid flags a supported funct.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       valid
);

    always_comb begin
        alu_ctl = AluAnd;
        valid   = 1'b1;
        case (funct)
            FnAdd:   alu_ctl = AluAdd;
            FnSub:   alu_ctl = AluSub;
            FnAnd:   alu_ctl = AluAnd;
            FnOr:    alu_ctl = AluOr;
            FnSlt:   alu_ctl = AluSlt;
            default: valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: Moore outputs from the registered state, with
// pc_en gated by zero in BRANCH and alu_ctl taken from funct in RTEXEC.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int unsigned MEM_HS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_ctl,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic       is_store_q, is_store_d;
    logic       ready;
    logic [2:0] rt_ctl;
    logic       rt_valid;

    assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign state = state_q;

    mips_alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_ctl (rt_ctl),
        .valid   (rt_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        alu_ctl    = AluAnd;
        pc_en      = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = AluAdd;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                alu_ctl   = AluAdd;
                // The lw/sw split is latched here so MEMADR does not depend on opcode.
                case (opcode)
                    OpRtype: state_d = StRtExec;
                    OpLw, OpSw: begin
                        state_d    = StMemAdr;
                        is_store_d = (opcode == OpSw);
                    end
                    OpBeq:  state_d = StBranch;
                    OpAddi: state_d = StAddiEx;
                    OpJ:    state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = AluAdd;
                state_d   = is_store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (ready) state_d = StFetch;
            end
            StRtExec: begin
                alu_src_a = 1'b1;
                alu_ctl   = rt_ctl;
                illegal   = !rt_valid;
                state_d   = rt_valid ? StRtWb : StFetch;
            end
            StRtWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_ctl   = AluSub;
                pc_source = 2'b01;
                pc_en     = zero;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = AluAdd;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset holds the FSM in FETCH, but FETCH must not drive the datapath then.
        if (!reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_source  = 2'b00;
            alu_ctl    = 3'b000;
            pc_en      = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle stimulus and expected state/outputs
// are queued together, then drained and compared cycle by cycle.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_ctl;
    logic       pc_en, illegal;
    logic [3:0] state;
    logic [16:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] vec;
        logic [16:0] mask;
        string       tag;
    } step_t;

    step_t sb[$];

    always #5 clk = ~clk;

    mips_mc_controller #(.MEM_HS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_ctl    (alu_ctl),
        .pc_en      (pc_en),
        .illegal    (illegal),
        .state      (state)
    );

    assign obs = {mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, pc_source, alu_ctl, pc_en, illegal};

    // Expected output vector per state, written from the control table.
    function automatic logic [16:0] exp_vec(input int st, input logic rdy, input logic z,
                                            input logic ill, input logic [2:0] rctl);
        logic mr, mw, irw, io, rw, rd, m2r, asa, pe;
        logic [1:0] asb, pcs;
        logic [2:0] ac;
        {mr, mw, irw, io, rw, rd, m2r, asa, pe} = '0;
        asb = 2'b00; pcs = 2'b00; ac = 3'b000;
        case (st)
            0:  begin mr = 1; asb = 2'b01; ac = 3'b010; irw = rdy; pe = rdy; end
            1:  begin asb = 2'b11; ac = 3'b010; end
            2:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; ac = rctl; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; ac = 3'b110; pcs = 2'b01; pe = z; end
            9:  begin asa = 1; asb = 2'b10; ac = 3'b010; end
            10: begin rw = 1; end
            11: begin pcs = 2'b10; pe = 1; end
            default: ;
        endcase
        return {mr, mw, irw, io, rw, rd, m2r, asa, asb, pcs, ac, pe, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rdy, input int st, input logic ill, input logic [2:0] rctl,
                        input string tag);
        step_t s;
        s.op   = op;
        s.fn   = fn;
        s.z    = z;
        s.rdy  = rdy;
        s.st   = 4'(st);
        s.vec  = exp_vec(st, rdy, z, ill, rctl);
        s.mask = 17'h1FFFF;
        s.tag  = tag;
        sb.push_back(s);
    endtask

    // Drive each queued step at a falling edge, sample 1ns later, then advance one cycle.
    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode    = s.op;
            funct     = s.fn;
            zero      = s.z;
            mem_ready = s.rdy;
            #1;
            check({s.tag, "_state"}, 32'(state), 32'(s.st));
            check({s.tag, "_outs"}, 32'(obs & s.mask), 32'(s.vec & s.mask));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0]  fns[4];
        logic [2:0]  ctls[4];
        fns  = '{6'h22, 6'h24, 6'h25, 6'h2A};
        ctls = '{3'b110, 3'b000, 3'b001, 3'b111};

        reset = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(obs), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // R-type add
        push(6'h00, 6'h20, 0, 1, 0, 0, 3'b000, "add");
        push(6'h00, 6'h20, 0, 1, 1, 0, 3'b000, "add");
        push(6'h00, 6'h20, 0, 1, 6, 0, 3'b010, "add");
        push(6'h00, 6'h20, 0, 1, 7, 0, 3'b000, "add");
        for (int i = 0; i < 4; i++) begin
            push(6'h00, fns[i], 0, 1, 0, 0, 3'b000, "rfn");
            push(6'h00, fns[i], 0, 1, 1, 0, 3'b000, "rfn");
            push(6'h00, fns[i], 0, 1, 6, 0, ctls[i], "rfn");
            push(6'h00, fns[i], 0, 1, 7, 0, 3'b000, "rfn");
        end
        // lw with two wait cycles in MEMRD
        push(6'h23, 6'h00, 0, 1, 0, 0, 3'b000, "lw");
        push(6'h23, 6'h00, 0, 1, 1, 0, 3'b000, "lw");
        push(6'h23, 6'h00, 0, 1, 2, 0, 3'b000, "lw");
        push(6'h23, 6'h00, 0, 0, 3, 0, 3'b000, "lw_wait");
        push(6'h23, 6'h00, 0, 0, 3, 0, 3'b000, "lw_wait");
        push(6'h23, 6'h00, 0, 1, 3, 0, 3'b000, "lw");
        push(6'h23, 6'h00, 0, 1, 4, 0, 3'b000, "lw");
        // sw with one wait cycle
        push(6'h2B, 6'h00, 0, 1, 0, 0, 3'b000, "sw");
        push(6'h2B, 6'h00, 0, 1, 1, 0, 3'b000, "sw");
        push(6'h2B, 6'h00, 0, 1, 2, 0, 3'b000, "sw");
        push(6'h2B, 6'h00, 0, 0, 5, 0, 3'b000, "sw_wait");
        push(6'h2B, 6'h00, 0, 1, 5, 0, 3'b000, "sw");
        // beq taken then not taken
        push(6'h04, 6'h00, 1, 1, 0, 0, 3'b000, "beq_t");
        push(6'h04, 6'h00, 1, 1, 1, 0, 3'b000, "beq_t");
        push(6'h04, 6'h00, 1, 1, 8, 0, 3'b000, "beq_t");
        push(6'h04, 6'h00, 0, 1, 0, 0, 3'b000, "beq_n");
        push(6'h04, 6'h00, 0, 1, 1, 0, 3'b000, "beq_n");
        push(6'h04, 6'h00, 0, 1, 8, 0, 3'b000, "beq_n");
        // illegal opcode
        push(6'h3F, 6'h00, 0, 1, 0, 0, 3'b000, "ill_op");
        push(6'h3F, 6'h00, 0, 1, 1, 1, 3'b000, "ill_op");
        // j then addi back to back
        push(6'h02, 6'h00, 0, 1, 0, 0, 3'b000, "j");
        push(6'h02, 6'h00, 0, 1, 1, 0, 3'b000, "j");
        push(6'h02, 6'h00, 0, 1, 11, 0, 3'b000, "j");
        push(6'h08, 6'h00, 0, 1, 0, 0, 3'b000, "addi");
        push(6'h08, 6'h00, 0, 1, 1, 0, 3'b000, "addi");
        push(6'h08, 6'h00, 0, 1, 9, 0, 3'b000, "addi");
        push(6'h08, 6'h00, 0, 1, 10, 0, 3'b000, "addi");
        // unsupported funct; alu_ctl is unspecified there
        push(6'h00, 6'h3F, 0, 1, 0, 0, 3'b000, "ill_fn");
        push(6'h00, 6'h3F, 0, 1, 1, 0, 3'b000, "ill_fn");
        push(6'h00, 6'h3F, 0, 1, 6, 1, 3'b000, "ill_fn");
        sb[$].mask = 17'h1FFE3;
        push(6'h00, 6'h3F, 0, 1, 0, 0, 3'b000, "ill_fn_ret");
        // sw parked in MEMWR for the asynchronous reset
        push(6'h2B, 6'h00, 0, 1, 1, 0, 3'b000, "sw_rst");
        push(6'h2B, 6'h00, 0, 1, 2, 0, 3'b000, "sw_rst");
        push(6'h2B, 6'h00, 0, 0, 5, 0, 3'b000, "sw_rst");
        drain();

        mem_ready = 1'b0;
        #2;
        check("memwr_before_rst", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_memwrite", 32'(mem_write), 32'd0);
        check("async_rst_outs", 32'(obs), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_held_state", 32'(state), 32'd0);
        check("rst_held_outs", 32'(obs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        push(6'h00, 6'h20, 0, 1, 0, 0, 3'b000, "post_rst");
        push(6'h00, 6'h20, 0, 1, 1, 0, 3'b000, "post_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
